rv32_decode_stage: RTL and testbench

Registered RV32I subset instruction decoder for the dual-issue out-of-order core; one copy per fetch slot. It converts a 32-bit instruction from the IF/DE register into architectural register indices, a sign-extended immediate, a 4-bit ALU opcode and a 5-bit control vector. Its outputs feed the rename stage, the DE/R pipeline register and the dispatch/issue logic.

---
 rtl/rv32_decode_stage_if.sv | 41 ++++
 rtl/rv32_decode_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rv32_decode_stage_if.sv
// ----------------------------------------------------------------------------
// rv32_decode_stage_if
// Bundles the decoder's instruction input and its decoded outputs.
//   master : the IF/DE side, which drives instr_i and observes the decode
//   slave  : the decoder, which consumes instr_i and drives the decode
// Signals:
//   instr_i   [INSTR_SIZE-1:0]      instruction to decode
//   rd_o      [clog2(NUM_A_REGS)-1:0] destination register index
//   rs1_o     [clog2(NUM_A_REGS)-1:0] source register 1 index
//   rs2_o     [clog2(NUM_A_REGS)-1:0] source register 2 index
//   imm_o     [WORD_SIZE-1:0]       immediate
//   alu_op_o  [ALU_OP_SIZE-1:0]     ALU operation
//   control_o [CONTR_SIG_SIZE-1:0]  {memwr, memre, alusrc, regwrite, valid}
// ----------------------------------------------------------------------------
interface rv32_decode_stage_if #(
   parameter int INSTR_SIZE     = 32,
   parameter int WORD_SIZE      = 32,
   parameter int NUM_A_REGS     = 32,
   parameter int ALU_OP_SIZE    = 4,
   parameter int CONTR_SIG_SIZE = 5
);
   localparam int REG_IDX_W = $clog2(NUM_A_REGS);

   logic [INSTR_SIZE-1:0]     instr_i;
   logic [REG_IDX_W-1:0]      rd_o;
   logic [REG_IDX_W-1:0]      rs1_o;
   logic [REG_IDX_W-1:0]      rs2_o;
   logic [WORD_SIZE-1:0]      imm_o;
   logic [ALU_OP_SIZE-1:0]    alu_op_o;
   logic [CONTR_SIG_SIZE-1:0] control_o;

   modport master (
      output instr_i,
      input  rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o
   );

   modport slave (
      input  instr_i,
      output rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o
   );
endinterface

// File: rtl/rv32_decode_stage.sv
// ----------------------------------------------------------------------------
// rv32_decode_stage
// Registered RV32I-subset decoder, one per fetch slot. Decodes ADD/SUB/AND/
// XOR/SRA, ADDI/XORI/ANDI/SRAI, LW and SW into register indices, immediate,
// ALU opcode and control vector, all registered with 1-cycle latency.
// Optional feature: define DECODE_LUI_EN to also decode LUI; without it LUI
// decodes as an invalid instruction.
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset (overrides instr_i)
//   bus    : rv32_decode_stage_if.slave (instr_i in, decoded fields out)
// ----------------------------------------------------------------------------
module rv32_decode_stage #(
   parameter int INSTR_SIZE     = 32,
   parameter int WORD_SIZE      = 32,
   parameter int NUM_A_REGS     = 32,
   parameter int ALU_OP_SIZE    = 4,
   parameter int CONTR_SIG_SIZE = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   rv32_decode_stage_if.slave  bus
);
   localparam int REG_IDX_W = $clog2(NUM_A_REGS);

   localparam logic [ALU_OP_SIZE-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_OP_SIZE-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_OP_SIZE-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_OP_SIZE-1:0] ALU_XOR = 4'b1000;
   localparam logic [ALU_OP_SIZE-1:0] ALU_SRA = 4'b1001;

   localparam int CONTR_VALID_INDEX    = 0;
   localparam int CONTR_REGWRITE_INDEX = 1;
   localparam int CONTR_ALUSRC_INDEX   = 2;
   localparam int CONTR_MEMRE_INDEX    = 3;
   localparam int CONTR_MEMWR_INDEX    = 4;

   typedef enum logic [6:0] {
      OPC_R    = 7'b0110011,
      OPC_IALU = 7'b0010011,
      OPC_LOAD = 7'b0000011,
      OPC_STOR = 7'b0100011,
      OPC_LUI  = 7'b0110111
   } opcode_e;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRA = 3'b101;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Instruction fields
   logic [INSTR_SIZE-1:0] w_instr;
   logic [6:0]            w_opcode;
   logic [2:0]            w_f3;
   logic [6:0]            w_f7;
   logic [REG_IDX_W-1:0]  w_fld_rd;
   logic [REG_IDX_W-1:0]  w_fld_rs1;
   logic [REG_IDX_W-1:0]  w_fld_rs2;
   logic [WORD_SIZE-1:0]  w_imm_i;
   logic [WORD_SIZE-1:0]  w_imm_s;

   assign w_instr   = bus.instr_i;
   assign w_opcode  = w_instr[6:0];
   assign w_f3      = w_instr[14:12];
   assign w_f7      = w_instr[31:25];
   assign w_fld_rd  = w_instr[11:7];
   assign w_fld_rs1 = w_instr[19:15];
   assign w_fld_rs2 = w_instr[24:20];
   assign w_imm_i   = {{(WORD_SIZE-12){w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s   = {{(WORD_SIZE-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};

   // Next-state decode
   logic [REG_IDX_W-1:0]      w_rd;
   logic [REG_IDX_W-1:0]      w_rs1;
   logic [REG_IDX_W-1:0]      w_rs2;
   logic [WORD_SIZE-1:0]      w_imm;
   logic [ALU_OP_SIZE-1:0]    w_alu_op;
   logic [CONTR_SIG_SIZE-1:0] w_ctrl;

   always_comb begin
      // NOTE: every output gets a default first, so no path through the case
      // leaves a signal unassigned and no latch is inferred. The defaults are
      // exactly the invalid-instruction decode.
      w_rd     = '0;
      w_rs1    = '0;
      w_rs2    = '0;
      w_imm    = '0;
      w_alu_op = ALU_ADD;
      w_ctrl   = '0;

      case (w_opcode)
         OPC_R: begin
            // Only the five supported f3/f7 pairs are valid.
            if (w_f7 == F7_BASE && w_f3 == F3_ADD) begin
               w_alu_op = ALU_ADD;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
               w_alu_op = ALU_SUB;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f7 == F7_BASE && w_f3 == F3_AND) begin
               w_alu_op = ALU_AND;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f7 == F7_BASE && w_f3 == F3_XOR) begin
               w_alu_op = ALU_XOR;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f7 == F7_ALT && w_f3 == F3_SRA) begin
               w_alu_op = ALU_SRA;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end
            if (w_ctrl[CONTR_VALID_INDEX]) begin
               w_rd  = w_fld_rd;
               w_rs1 = w_fld_rs1;
               w_rs2 = w_fld_rs2;
               w_ctrl[CONTR_REGWRITE_INDEX] = 1'b1;
            end
         end

         OPC_IALU: begin
            if (w_f3 == F3_ADD) begin
               w_alu_op = ALU_ADD;
               w_imm    = w_imm_i;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f3 == F3_XOR) begin
               w_alu_op = ALU_XOR;
               w_imm    = w_imm_i;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f3 == F3_AND) begin
               w_alu_op = ALU_AND;
               w_imm    = w_imm_i;
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end else if (w_f3 == F3_SRA && w_f7 == F7_ALT) begin
               // The shift amount is unsigned; bit 30 only selects SRA.
               w_alu_op = ALU_SRA;
               w_imm    = {{(WORD_SIZE-5){1'b0}}, w_instr[24:20]};
               w_ctrl[CONTR_VALID_INDEX] = 1'b1;
            end
            if (w_ctrl[CONTR_VALID_INDEX]) begin
               w_rd  = w_fld_rd;
               w_rs1 = w_fld_rs1;
               w_ctrl[CONTR_REGWRITE_INDEX] = 1'b1;
               w_ctrl[CONTR_ALUSRC_INDEX]   = 1'b1;
            end
         end

         OPC_LOAD: begin
            if (w_f3 == F3_W) begin
               w_rd  = w_fld_rd;
               w_rs1 = w_fld_rs1;
               w_imm = w_imm_i;
               w_ctrl[CONTR_VALID_INDEX]    = 1'b1;
               w_ctrl[CONTR_REGWRITE_INDEX] = 1'b1;
               w_ctrl[CONTR_ALUSRC_INDEX]   = 1'b1;
               w_ctrl[CONTR_MEMRE_INDEX]    = 1'b1;
            end
         end

         OPC_STOR: begin
            if (w_f3 == F3_W) begin
               w_rs1 = w_fld_rs1;
               w_rs2 = w_fld_rs2;
               w_imm = w_imm_s;
               w_ctrl[CONTR_VALID_INDEX]  = 1'b1;
               w_ctrl[CONTR_ALUSRC_INDEX] = 1'b1;
               w_ctrl[CONTR_MEMWR_INDEX]  = 1'b1;
            end
         end

`ifdef DECODE_LUI_EN
         OPC_LUI: begin
            w_rd  = w_fld_rd;
            w_imm = {{(WORD_SIZE-31){w_instr[31]}}, w_instr[30:12], 12'b0};
            w_ctrl[CONTR_VALID_INDEX]    = 1'b1;
            w_ctrl[CONTR_REGWRITE_INDEX] = 1'b1;
            w_ctrl[CONTR_ALUSRC_INDEX]   = 1'b1;
         end
`endif

         default: ;
      endcase

      // Writes to x0 are architecturally discarded; the op stays valid.
      if (w_rd == '0) w_ctrl[CONTR_REGWRITE_INDEX] = 1'b0;
   end

   // Output registers
   logic [REG_IDX_W-1:0]      r_rd;
   logic [REG_IDX_W-1:0]      r_rs1;
   logic [REG_IDX_W-1:0]      r_rs2;
   logic [WORD_SIZE-1:0]      r_imm;
   logic [ALU_OP_SIZE-1:0]    r_alu_op;
   logic [CONTR_SIG_SIZE-1:0] r_ctrl;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd     <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_imm    <= '0;
         r_alu_op <= ALU_ADD;
         r_ctrl   <= '0;
      end else begin
         r_rd     <= w_rd;
         r_rs1    <= w_rs1;
         r_rs2    <= w_rs2;
         r_imm    <= w_imm;
         r_alu_op <= w_alu_op;
         r_ctrl   <= w_ctrl;
      end
   end

   assign bus.rd_o      = r_rd;
   assign bus.rs1_o     = r_rs1;
   assign bus.rs2_o     = r_rs2;
   assign bus.imm_o     = r_imm;
   assign bus.alu_op_o  = r_alu_op;
   assign bus.control_o = r_ctrl;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_rv32_decode_stage
// Self-checking bench for rv32_decode_stage. A stimulus process drives one
// instruction (or reset) per cycle and queues the expected decode; a monitor
// pops and compares one entry per cycle after the capturing edge.
// ----------------------------------------------------------------------------
module tb_rv32_decode_stage;
   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [4:0]  ctrl;   // {memwr, memre, alusrc, regwrite, valid}
   } exp_t;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      exp_t        exp;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   stim_done = 1'b0;
   exp_t exp_q[$];

   rv32_decode_stage_if bus ();

   rv32_decode_stage dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Reference model: classify the instruction, then derive every field from
   // its format and the class-level control rules.
   typedef enum {K_INV, K_R, K_I, K_LW, K_SW, K_LUI} kind_e;

   function automatic exp_t model(input logic [31:0] ins, input logic rst);
      exp_t e;
      kind_e k;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [11:0] s_imm;
      e = '0;
      e.alu = 4'b0010;
      if (rst) return e;
      opc = ins[6:0];
      f3  = ins[14:12];
      f7  = ins[31:25];
      k   = K_INV;
      if (opc == 7'h33) begin
         if      (f3 == 0 && f7 == 7'h00) begin k = K_R; e.alu = 4'b0010; end
         else if (f3 == 0 && f7 == 7'h20) begin k = K_R; e.alu = 4'b0110; end
         else if (f3 == 7 && f7 == 7'h00) begin k = K_R; e.alu = 4'b0000; end
         else if (f3 == 4 && f7 == 7'h00) begin k = K_R; e.alu = 4'b1000; end
         else if (f3 == 5 && f7 == 7'h20) begin k = K_R; e.alu = 4'b1001; end
      end else if (opc == 7'h13) begin
         if      (f3 == 0) begin k = K_I; e.alu = 4'b0010; end
         else if (f3 == 4) begin k = K_I; e.alu = 4'b1000; end
         else if (f3 == 7) begin k = K_I; e.alu = 4'b0000; end
         else if (f3 == 5 && f7 == 7'h20) begin k = K_I; e.alu = 4'b1001; end
      end else if (opc == 7'h03 && f3 == 2) k = K_LW;
      else if (opc == 7'h23 && f3 == 2) k = K_SW;
`ifdef DECODE_LUI_EN
      else if (opc == 7'h37) k = K_LUI;
`endif
      if (k == K_INV) return e;

      if (k != K_SW)                  e.rd  = ins[11:7];
      if (k != K_LUI)                 e.rs1 = ins[19:15];
      if (k == K_R || k == K_SW)      e.rs2 = ins[24:20];
      case (k)
         K_I:   e.imm = (e.alu == 4'b1001) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
         K_LW:  e.imm = 32'($signed(ins[31:20]));
         K_SW:  begin s_imm = {ins[31:25], ins[11:7]}; e.imm = 32'($signed(s_imm)); end
         K_LUI: e.imm = ins & 32'hFFFF_F000;
         default: e.imm = 32'd0;
      endcase
      e.ctrl[0] = 1'b1;
      e.ctrl[1] = (k != K_SW) && (e.rd != 0);
      e.ctrl[2] = (k != K_R);
      e.ctrl[3] = (k == K_LW);
      e.ctrl[4] = (k == K_SW);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0] opcs [6];
      logic [6:0] f7s [3];
      opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h33};
      f7s  = '{7'h00, 7'h20, 7'h00};
      w = $urandom();
      if ($urandom_range(0, 7) == 0) return w;   // fully random word
      w[6:0] = opcs[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 2)];
      if (($urandom_range(0, 1) == 0) && (w[6:0] == 7'h03 || w[6:0] == 7'h23)) w[14:12] = 3'b010;
      if ($urandom_range(0, 9) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   // Monitor: one queued expectation is due each cycle, just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd",      32'(bus.rd_o),      32'(e.rd));
            check("rs1",     32'(bus.rs1_o),     32'(e.rs1));
            check("rs2",     32'(bus.rs2_o),     32'(e.rs2));
            check("imm",     bus.imm_o,          e.imm);
            check("alu_op",  32'(bus.alu_op_o),  32'(e.alu));
            check("control", 32'(bus.control_o), 32'(e.ctrl));
         end
      end
   end

   // Stimulus
   initial begin
      vec_t dir[$];
      exp_t rst_exp;
      rst_exp = '{rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, alu: 4'b0010, ctrl: 5'b00000};

      dir.push_back('{1'b1, 32'h0050_0093, rst_exp});
      dir.push_back('{1'b0, 32'h0050_0093, '{5'd1, 5'd0, 5'd0, 32'd5, 4'b0010, 5'b00111}});
      dir.push_back('{1'b0, 32'h4020_81B3, '{5'd3, 5'd1, 5'd2, 32'd0, 4'b0110, 5'b00011}});
      dir.push_back('{1'b0, 32'hFFC1_2283, '{5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 4'b0010, 5'b01111}});
      dir.push_back('{1'b0, 32'h0051_2423, '{5'd0, 5'd2, 5'd5, 32'd8, 4'b0010, 5'b10101}});
      dir.push_back('{1'b0, 32'h4030_D213, '{5'd4, 5'd1, 5'd0, 32'd3, 4'b1001, 5'b00111}});
      dir.push_back('{1'b0, 32'h0000_0013, '{5'd0, 5'd0, 5'd0, 32'd0, 4'b0010, 5'b00101}});
      dir.push_back('{1'b0, 32'h0000_0000, rst_exp});
`ifdef DECODE_LUI_EN
      dir.push_back('{1'b0, 32'h1234_52B7, '{5'd5, 5'd0, 5'd0, 32'h1234_5000, 4'b0010, 5'b00111}});
`else
      dir.push_back('{1'b0, 32'h1234_52B7, rst_exp});
`endif
      // Mid-stream reset overrides a valid instruction, decode resumes after.
      dir.push_back('{1'b0, 32'h0050_0093, '{5'd1, 5'd0, 5'd0, 32'd5, 4'b0010, 5'b00111}});
      dir.push_back('{1'b1, 32'h4020_81B3, rst_exp});
      dir.push_back('{1'b0, 32'h0051_2423, '{5'd0, 5'd2, 5'd5, 32'd8, 4'b0010, 5'b10101}});

      foreach (dir[i]) begin
         @(negedge clk_i);
         rst_i       = dir[i].rst;
         bus.instr_i = dir[i].instr;
         exp_q.push_back(dir[i].exp);
      end

      for (int n = 0; n < 400; n++) begin
         logic r;
         logic [31:0] w;
         @(negedge clk_i);
         r = ($urandom_range(0, 49) == 0);
         w = rand_instr();
         rst_i       = r;
         bus.instr_i = w;
         exp_q.push_back(model(w, r));
      end

      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      stim_done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      if (!stim_done) begin
         $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
         $fatal(1, "timeout");
      end
   end
endmodule
